// File: rtl/dcache_wb_pkg.sv
// Shared types for the write-back data cache: FSM state encoding and data width.
package dcache_wb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } dc_state_e;

endpackage

// File: rtl/dcache_store.sv
// Tag/valid/dirty/data arrays: combinational read of one line, one word write
// plus one metadata write per cycle, both addressed by wr_idx.
module dcache_store
    import dcache_wb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINE_NUM   = 64,
    parameter int TAG        = 22
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [$clog2(LINE_NUM)-1:0]            rd_idx,
    output logic                                   rd_valid,
    output logic                                   rd_dirty,
    output logic [TAG-1:0]                         rd_tag,
    output logic [LINE_WORDS-1:0][DATA_W-1:0]      rd_line,
    input  logic [$clog2(LINE_NUM)-1:0]            wr_idx,
    input  logic                                   word_we,
    input  logic [$clog2(LINE_WORDS)-1:0]          wr_word,
    input  logic [DATA_W-1:0]                      wr_data,
    input  logic                                   meta_we,
    input  logic [TAG-1:0]                         meta_tag,
    input  logic                                   meta_valid,
    input  logic                                   meta_dirty
);

    logic [LINE_NUM-1:0]                valid_q, valid_d;
    logic [LINE_NUM-1:0]                dirty_q, dirty_d;
    logic [TAG-1:0]                     tag_q  [LINE_NUM];
    logic [LINE_WORDS-1:0][DATA_W-1:0]  data_q [LINE_NUM];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (meta_we) begin
            valid_d[wr_idx] = meta_valid;
            dirty_d[wr_idx] = meta_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and data are left uninitialised on reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (word_we)
            data_q[wr_idx][wr_word] <= wr_data;
        if (meta_we)
            tag_q[wr_idx] <= meta_tag;
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache: same-cycle hits,
// stalling miss handling with dirty-line writeback followed by line refill.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINE_NUM   = 64,
    parameter int ADDR_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_ren,
    input  logic                 cpu_wen,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]    cpu_din,
    output logic [DATA_W-1:0]    cpu_dout,
    output logic                 cpu_stall,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_dout,
    input  logic [DATA_W-1:0]    mem_din,
    input  logic                 mem_ack
);

    localparam int WB  = $clog2(LINE_WORDS);
    localparam int OFS = WB + 2;
    localparam int IDX = $clog2(LINE_NUM);
    localparam int TAG = ADDR_BITS - IDX - OFS;

    dc_state_e       state_q, state_d;
    logic [WB-1:0]   cnt_q, cnt_d;

    logic [TAG-1:0]  cpu_tag;
    logic [IDX-1:0]  cpu_idx;
    logic [WB-1:0]   cpu_word;
    logic            req, hit, last_beat;
    logic            unused_addr_lsb;

    logic                              rd_valid, rd_dirty;
    logic [TAG-1:0]                    rd_tag;
    logic [LINE_WORDS-1:0][DATA_W-1:0] rd_line;
    logic                              word_we, meta_we, meta_valid, meta_dirty;
    logic [WB-1:0]                     wr_word;
    logic [DATA_W-1:0]                 wr_data;
    logic [TAG-1:0]                    meta_tag;

    assign cpu_tag         = cpu_addr[ADDR_BITS-1 -: TAG];
    assign cpu_idx         = cpu_addr[OFS +: IDX];
    assign cpu_word        = cpu_addr[2 +: WB];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign req       = cpu_ren | cpu_wen;
    assign hit       = req & rd_valid & (rd_tag == cpu_tag);
    assign last_beat = (cnt_q == WB'(LINE_WORDS - 1));

    dcache_store #(
        .LINE_WORDS (LINE_WORDS),
        .LINE_NUM   (LINE_NUM),
        .TAG        (TAG)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (cpu_idx),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .wr_idx     (cpu_idx),
        .word_we    (word_we),
        .wr_word    (wr_word),
        .wr_data    (wr_data),
        .meta_we    (meta_we),
        .meta_tag   (meta_tag),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty)
    );

    // The cpu request is held during a miss, so its index and tag address
    // both the victim readout and the refill for the whole transaction.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_we    = 1'b0;
        wr_word    = cpu_word;
        wr_data    = cpu_din;
        meta_we    = 1'b0;
        meta_tag   = cpu_tag;
        meta_valid = 1'b1;
        meta_dirty = 1'b0;
        cpu_stall  = 1'b0;
        cpu_dout   = '0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_dout   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    if (cpu_wen) begin
                        word_we    = 1'b1;
                        meta_we    = 1'b1;
                        meta_dirty = 1'b1;
                    end else begin
                        cpu_dout = rd_line[cpu_word];
                    end
                end else if (req) begin
                    cpu_stall = 1'b1;
                    cnt_d     = '0;
                    state_d   = (rd_valid & rd_dirty) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                cpu_stall = 1'b1;
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, cpu_idx, cnt_q, 2'b00};
                mem_dout  = rd_line[cnt_q];
                if (mem_ack) begin
                    cnt_d = cnt_q + WB'(1);
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                cpu_stall = 1'b1;
                mem_cs    = 1'b1;
                mem_addr  = {cpu_tag, cpu_idx, cnt_q, 2'b00};
                if (mem_ack) begin
                    word_we = 1'b1;
                    wr_word = cnt_q;
                    wr_data = mem_din;
                    cnt_d   = cnt_q + WB'(1);
                    if (last_beat) begin
                        cnt_d   = '0;
                        meta_we = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core's MEM-stage memory interface (ren/wen/addr/dout/din) and the word-wide main data memory.
- Hits complete in the same cycle with no stall.
- On a miss it stalls the pipeline, writes back the victim line if it is dirty, refills the line, and then completes the access.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, 2..16)
- LINE_NUM, 64, number of lines (power of 2)
- ADDR_BITS, 32, byte address width
- Derived values, not overridable:
  - OFS = log2(LINE_WORDS)+2
  - IDX = log2(LINE_NUM)
  - TAG = ADDR_BITS-IDX-OFS

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- cpu_ren  in  1  load request from MEM stage
- cpu_wen  in  1  store request from MEM stage (word store)
- cpu_addr  in  ADDR_BITS  byte address; bits [1:0] are ignored
- cpu_din  in  32  store data
- cpu_dout  out  32  load data
- cpu_stall  out  1  holds the pipeline while the request cannot complete
- mem_cs  out  1  main-memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_BITS  word-aligned byte address
- mem_dout  out  32  write data to memory
- mem_din  in  32  read data from memory
- mem_ack  in  1  one-cycle acknowledge per word; read data is valid with ack

Interface decision: one clock, clk; reset is rst, synchronous and active-high.

Behaviour:
- Storage:
  - Per line: valid, dirty, TAG-bit tag, LINE_WORDS x 32 data.
  - Address split: tag = addr[ADDR_BITS-1:IDX+OFS], index = addr[IDX+OFS-1:OFS], word = addr[OFS-1:2].
- Reset:
  - All valid and dirty bits are cleared (data and tags are not cleared).
  - FSM goes to S_IDLE.
  - Outputs: mem_cs=0, mem_we=0, mem_addr=0, mem_dout=0, cpu_stall=0, cpu_dout=0.
  - A reset mid-refill abandons the transfer; any partially written line stays invalid.
- hit = req & valid[index] & (tag match), where req = cpu_ren|cpu_wen.
- S_IDLE:
  - Load hit: cpu_dout = line word, driven combinationally in the same cycle; cpu_stall=0.
  - Store hit: the word is written at the clk edge and dirty is set; cpu_stall=0.
  - Miss: cpu_stall=1 combinationally in the same cycle. Next state is S_WB if valid&dirty, otherwise S_FILL. The word counter is cleared.
  - No request: cpu_stall=0, cpu_dout holds 0.
- S_WB:
  - mem_cs=1, mem_we=1, mem_addr = {old tag, index, cnt, 2'b00}, mem_dout = data[cnt].
  - Each mem_ack increments cnt.
  - After the ack on cnt=LINE_WORDS-1: clear cnt, go to S_FILL.
- S_FILL:
  - mem_cs=1, mem_we=0, mem_addr = {cpu tag, index, cnt, 2'b00}.
  - Each mem_ack writes mem_din into data[cnt] and increments cnt.
  - After the last ack: set tag, valid=1, dirty=0, go to S_IDLE.
  - The access now hits in S_IDLE and completes there.
- Stall and miss latency:
  - cpu_stall=1 throughout S_WB and S_FILL.
  - Miss latency, clean victim = LINE_WORDS acks + 1 cycle. Dirty victim adds LINE_WORDS acks.
- Boundaries:
  - No ack means the FSM waits indefinitely with mem_* held stable.
  - cpu_ren & cpu_wen together: treated as a store.
  - The cpu request must be held stable while cpu_stall=1; a changed request is not tracked.
  - cnt wraps only at the state change, never mid-line.
  - A request that changes between cycles in S_IDLE is evaluated fresh each cycle.

Decomposition:
- define.vh additions: DCACHE state encodings S_IDLE=2'd0, S_WB=2'd1, S_FILL=2'd2.
- Sub-module dcache_store: tag/valid/dirty/data arrays.
  - Combinational read port by index.
  - Synchronous write of a single word, plus tag/valid/dirty update.
- dcache_wb contains the FSM, word counter, and address muxing.

Test Plan:
- Cold load: after reset, cpu_ren at 0x0000_0104 with memory word[0x100+4k]=k+0xA0, ack every cycle. Required: stall for 5 cycles, 4 read beats at 0x100,0x104,0x108,0x10C, then cpu_dout=0xA1 with stall=0.
- Hit: load 0x0000_010C immediately after the cold load. Required: cpu_dout=0xA3 in the same cycle, stall=0, mem_cs=0.
- Store hit then dirty eviction:
  - Store 0xDEADBEEF to 0x104.
  - Then load 0x0000_1104 (same index, different tag).
  - Required: 4 write beats at 0x100..0x10C, the beat at 0x104 carrying 0xDEADBEEF; then 4 read beats at 0x1100..0x110C.
- Clean eviction: load a conflicting address after a line has only been read. Required: no write beats; fill only.
- Slow memory: ack every 3rd cycle. Required: mem_addr/mem_we/mem_dout held stable between acks; correct data delivered.
- Reset mid-fill: assert rst after 2 fill acks, then load the same address. Required: full 4-beat refill (the line is not valid).
